// File: rtl/input_port_if.sv
// Link-side handshake and output-port bus of the router input port.
// master = link/output-port side driving stimulus, slave = the input port itself.
interface input_port_if #(
  parameter int flitWidth         = 12,
  parameter int flitWidthModified = 14,
  parameter int CNT_WIDTH         = 16
);
  logic                         in_valid;
  logic [flitWidth-1:0]         in_flit;
  logic                         in_ready;
  logic [2:0]                   portBlock;
  logic [flitWidthModified-1:0] dataOut;
  logic                         drop_err;
  logic [CNT_WIDTH-1:0]         flit_count;

  modport master (
    output in_valid, in_flit, portBlock,
    input  in_ready, dataOut, drop_err, flit_count
  );

  modport slave (
    input  in_valid, in_flit, portBlock,
    output in_ready, dataOut, drop_err, flit_count
  );
endinterface

// File: rtl/input_port.sv
// Router input port: buffers routed flits in a FIFO and presents the head as {route, flit}.
// Latency: flit accepted at edge N appears on dataOut right after edge N when the FIFO was empty.
// Backpressure: in_ready drops when full; head stalls while its destination's portBlock bit is set.
// Optional forwarded-flit counter enabled by INPUT_PORT_FLIT_COUNT_EN.
module input_port #(
  parameter int flitWidth         = 12,
  parameter int flitWidthModified = 14,
  parameter int FIFO_DEPTH        = 4,
  parameter int CNT_WIDTH         = 16
) (
  input logic             clk,
  input logic             rst_n,
  input_port_if.slave     bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  logic [flitWidthModified-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [OCC_W-1:0]             count;
  logic                         rdy_en;
  logic                         drop_q;

  logic [1:0]                   route;
  logic [1:0]                   head_route;
  logic [flitWidthModified-1:0] head;
  logic                         full;
  logic                         empty;
  logic                         accept;
  logic                         push;
  logic                         pop;
  logic                         head_blk;

  assign route      = bus.in_flit[flitWidth-1 -: 2];
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  // rdy_en keeps in_ready low during reset and releases it on the first clock afterwards.
  assign bus.in_ready = rdy_en & ~full;
  assign accept     = bus.in_valid & bus.in_ready;
  assign push       = accept & (route != 2'b00);

  assign head       = mem[rd_ptr];
  assign head_route = head[flitWidthModified-1 -: 2];

  always_comb begin
    head_blk = 1'b1;
    case (head_route)
      2'b01:   head_blk = bus.portBlock[0];
      2'b10:   head_blk = bus.portBlock[1];
      2'b11:   head_blk = bus.portBlock[2];
      default: head_blk = 1'b1;
    endcase
  end

  assign pop          = ~empty & ~head_blk;
  assign bus.dataOut  = empty ? '0 : head;
  assign bus.drop_err = drop_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {route, bus.in_flit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      drop_q <= accept & (route == 2'b00);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef INPUT_PORT_FLIT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.flit_count = cnt_q;
`else
  assign bus.flit_count = '0;
`endif

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port: reset, single flit, backpressure, selective block, drop, streaming.
module tb_input_port;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  input_port_if #(.flitWidth(12), .flitWidthModified(14), .CNT_WIDTH(16)) pif ();

  input_port #(
    .flitWidth(12), .flitWidthModified(14), .FIFO_DEPTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef INPUT_PORT_FLIT_COUNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // Reset held with a valid flit on the link
    rst_n         = 1'b0;
    pif.in_valid  = 1'b1;
    pif.in_flit   = 12'h8A5;
    pif.portBlock = 3'b000;
    step();
    step();
    chk("rst_ready", 32'(pif.in_ready), 32'h0);
    chk("rst_data", 32'(pif.dataOut), 32'h0);
    chk("rst_drop", 32'(pif.drop_err), 32'h0);
    chk("rst_cnt", 32'(pif.flit_count), 32'h0);
    pif.in_valid = 1'b0;
    rst_n        = 1'b1;
    step();
    chk("rel_ready", 32'(pif.in_ready), 32'h1);
    chk("rel_data", 32'(pif.dataOut), 32'h0);

    // Single flit to port 2, unblocked
    pif.in_valid = 1'b1;
    pif.in_flit  = 12'h8A5;
    step();
    chk("single_out", 32'(pif.dataOut), 32'h28A5);
    pif.in_valid = 1'b0;
    step();
    chk("single_gone", 32'(pif.dataOut), 32'h0);
    chk("single_cnt", 32'(pif.flit_count), exp_cnt(1));

    // Backpressure: five flits to blocked port 3, only four fit
    pif.portBlock = 3'b100;
    for (int i = 0; i < 5; i++) begin
      pif.in_valid = 1'b1;
      pif.in_flit  = 12'hC01 + 12'(i);
      step();
    end
    chk("bp_ready", 32'(pif.in_ready), 32'h0);
    chk("bp_head", 32'(pif.dataOut), 32'h3C01);
    pif.in_valid  = 1'b0;
    step();
    chk("bp_hold", 32'(pif.dataOut), 32'h3C01);
    pif.portBlock = 3'b000;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", 32'(pif.dataOut), 32'h3C01 + 32'(i));
      step();
    end
    chk("bp_empty", 32'(pif.dataOut), 32'h0);
    chk("bp_ready_back", 32'(pif.in_ready), 32'h1);
    chk("bp_cnt", 32'(pif.flit_count), exp_cnt(5));

    // Selective block: port 1 head stalls on bit0, ignores bits 1/2
    pif.portBlock = 3'b001;
    pif.in_valid  = 1'b1;
    pif.in_flit   = 12'h4AB;
    step();
    pif.in_valid  = 1'b0;
    chk("sel_head", 32'(pif.dataOut), 32'h14AB);
    step();
    chk("sel_stall", 32'(pif.dataOut), 32'h14AB);
    chk("sel_stall_cnt", 32'(pif.flit_count), exp_cnt(5));
    pif.portBlock = 3'b110;
    step();
    chk("sel_pop", 32'(pif.dataOut), 32'h0);
    chk("sel_cnt", 32'(pif.flit_count), exp_cnt(6));

    // Drop: route-0 flit discarded while a blocked port-2 flit sits at head
    pif.portBlock = 3'b010;
    pif.in_valid  = 1'b1;
    pif.in_flit   = 12'h9C3;
    step();
    chk("drop_pre", 32'(pif.dataOut), 32'h29C3);
    pif.in_flit   = 12'h0FF;
    step();
    chk("drop_pulse", 32'(pif.drop_err), 32'h1);
    chk("drop_data", 32'(pif.dataOut), 32'h29C3);
    pif.in_valid  = 1'b0;
    step();
    chk("drop_end", 32'(pif.drop_err), 32'h0);
    chk("drop_data2", 32'(pif.dataOut), 32'h29C3);
    pif.portBlock = 3'b000;
    step();
    chk("drop_drain", 32'(pif.dataOut), 32'h0);
    chk("drop_cnt", 32'(pif.flit_count), exp_cnt(7));

    // Streaming: prime two entries, then push+pop each cycle across pointer wrap
    pif.portBlock = 3'b111;
    pif.in_valid  = 1'b1;
    pif.in_flit   = 12'hD01;
    step();
    pif.in_flit   = 12'hD02;
    step();
    pif.portBlock = 3'b000;
    for (int i = 0; i < 10; i++) begin
      pif.in_flit = 12'hD03 + 12'(i);
      chk("stream_head", 32'(pif.dataOut), 32'h3D01 + 32'(i));
      chk("stream_ready", 32'(pif.in_ready), 32'h1);
      step();
    end
    pif.in_valid = 1'b0;
    chk("stream_tail0", 32'(pif.dataOut), 32'h3D0B);
    step();
    chk("stream_tail1", 32'(pif.dataOut), 32'h3D0C);
    step();
    chk("stream_empty", 32'(pif.dataOut), 32'h0);
    chk("stream_cnt", 32'(pif.flit_count), exp_cnt(19));

    // Asynchronous reset with a buffered flit
    pif.portBlock = 3'b111;
    pif.in_valid  = 1'b1;
    pif.in_flit   = 12'h5A5;
    step();
    pif.in_valid  = 1'b0;
    chk("mid_head", 32'(pif.dataOut), 32'h15A5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(pif.dataOut), 32'h0);
    chk("mid_rst_ready", 32'(pif.in_ready), 32'h0);
    chk("mid_rst_cnt", 32'(pif.flit_count), 32'h0);
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 32'(pif.in_ready), 32'h1);
    chk("mid_rel_data", 32'(pif.dataOut), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
